// File: rtl/matrix_vector_mac.sv
// matrix_vector_mac: N x N matrix times N-vector, one multiply-accumulate per clock in row-major order,
// signed/unsigned operands, optional Y += A*V, per-row saturation with flags.
module matrix_vector_mac #(
  parameter int N = 4,
  parameter int ELEM_WIDTH = 4,
  parameter int OUT_WIDTH = 12
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         signed_mode,
  input  logic                         acc_mode,
  input  logic [N*N*ELEM_WIDTH-1:0]    A,
  input  logic [N*ELEM_WIDTH-1:0]      V,
  output logic [N*OUT_WIDTH-1:0]       Y,
  output logic [N-1:0]                 sat,
  output logic                         busy,
  output logic                         done
);
  localparam int EW = ELEM_WIDTH;
  localparam int OW = OUT_WIDTH;
  localparam int CW = $clog2(N);
  localparam int PW = 2 * EW + 2;
  // Wide enough for a full row sum plus an accumulated previous Y row, so it never wraps.
  localparam int AW = 2 * EW + CW + 2 + OW + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic signed [AW-1:0] UMAX = {{(AW-OW){1'b0}}, {OW{1'b1}}};
  localparam logic signed [AW-1:0] SMAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic accept, run, last;

  logic [N*N*EW-1:0] a_q, a_d;
  logic [N*EW-1:0] v_q, v_d;
  logic sm_q, sm_d, am_q, am_d;
  logic [CW-1:0] r_q, r_d, c_q, c_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [N*OW-1:0] ysh_q, ysh_d, y_q, y_d;
  logic [N-1:0] ssh_q, ssh_d, sat_q, sat_d;
  logic done_q, done_d;

  logic [EW-1:0] a_e, v_e;
  logic signed [EW:0] a_x, v_x;
  logic signed [PW-1:0] prod;
  logic [OW-1:0] y_row, res;
  logic signed [AW-1:0] base, sum, hi, lo;
  logic clamp_hi, clamp_lo;

  always_ff @(posedge clk)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;

  always_comb
    state_d = (state_q == IDLE) ? (start ? RUN : IDLE) : (last ? IDLE : RUN);

  always_comb begin
    run = state_q == RUN;
    busy = run;
    accept = (state_q == IDLE) && start;
    last = (r_q == LAST) && (c_q == LAST);
  end

  always_comb begin
    a_e = a_q[(int'(r_q) * N + int'(c_q)) * EW +: EW];
    v_e = v_q[int'(c_q) * EW +: EW];
    a_x = {sm_q & a_e[EW-1], a_e};
    v_x = {sm_q & v_e[EW-1], v_e};
    prod = a_x * v_x;
    y_row = y_q[int'(r_q) * OW +: OW];
    base = (c_q != '0) ? acc_q : am_q ? {{(AW-OW){sm_q & y_row[OW-1]}}, y_row} : '0;
    sum = base + {{(AW-PW){prod[PW-1]}}, prod};
    hi = sm_q ? SMAX : UMAX;
    lo = sm_q ? SMIN : '0;
    clamp_hi = sum > hi;
    clamp_lo = sum < lo;
    res = clamp_hi ? hi[OW-1:0] : clamp_lo ? lo[OW-1:0] : sum[OW-1:0];
  end

  always_comb begin
    a_d = accept ? A : a_q;
    v_d = accept ? V : v_q;
    sm_d = accept ? signed_mode : sm_q;
    am_d = accept ? acc_mode : am_q;
    c_d = accept || (run && c_q == LAST) ? '0 : run ? c_q + 1'b1 : c_q;
    r_d = accept || (run && last) ? '0 : (run && c_q == LAST) ? r_q + 1'b1 : r_q;
    acc_d = run ? sum : acc_q;
    ysh_d = ysh_q;
    ssh_d = ssh_q;
    if (run && c_q == LAST) begin
      ysh_d[int'(r_q) * OW +: OW] = res;
      ssh_d[r_q] = clamp_hi | clamp_lo;
    end
    // Publish whole result only at completion so Y never shows a partial update.
    y_d = (run && last) ? ysh_d : y_q;
    sat_d = (run && last) ? ssh_d : sat_q;
    done_d = run && last;
  end

  always_ff @(posedge clk)
    if (reset) begin
      a_q <= '0;
      v_q <= '0;
      sm_q <= 1'b0;
      am_q <= 1'b0;
      r_q <= '0;
      c_q <= '0;
      acc_q <= '0;
      ysh_q <= '0;
      ssh_q <= '0;
      y_q <= '0;
      sat_q <= '0;
      done_q <= 1'b0;
    end else begin
      a_q <= a_d;
      v_q <= v_d;
      sm_q <= sm_d;
      am_q <= am_d;
      r_q <= r_d;
      c_q <= c_d;
      acc_q <= acc_d;
      ysh_q <= ysh_d;
      ssh_q <= ssh_d;
      y_q <= y_d;
      sat_q <= sat_d;
      done_q <= done_d;
    end

  assign Y = y_q;
  assign sat = sat_q;
  assign done = done_q;
endmodule

// File: tb/tb_matrix_vector_mac.sv
// tb_matrix_vector_mac: scoreboard bench over three configurations (4/4/12, 4/4/8, 2/3/6).
module tb_matrix_vector_mac;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic start0, sm0, am0, busy0, done0;
  logic [63:0] A0;
  logic [15:0] V0;
  logic [47:0] Y0;
  logic [3:0] sat0;
  logic start1, sm1, am1, busy1, done1;
  logic [63:0] A1;
  logic [15:0] V1;
  logic [31:0] Y1;
  logic [3:0] sat1;
  logic start2, sm2, am2, busy2, done2;
  logic [11:0] A2;
  logic [5:0] V2;
  logic [11:0] Y2;
  logic [1:0] sat2;

  matrix_vector_mac #(.N(4), .ELEM_WIDTH(4), .OUT_WIDTH(12)) u0 (
    .clk(clk), .reset(rst), .start(start0), .signed_mode(sm0), .acc_mode(am0),
    .A(A0), .V(V0), .Y(Y0), .sat(sat0), .busy(busy0), .done(done0));
  matrix_vector_mac #(.N(4), .ELEM_WIDTH(4), .OUT_WIDTH(8)) u1 (
    .clk(clk), .reset(rst), .start(start1), .signed_mode(sm1), .acc_mode(am1),
    .A(A1), .V(V1), .Y(Y1), .sat(sat1), .busy(busy1), .done(done1));
  matrix_vector_mac #(.N(2), .ELEM_WIDTH(3), .OUT_WIDTH(6)) u2 (
    .clk(clk), .reset(rst), .start(start2), .signed_mode(sm2), .acc_mode(am2),
    .A(A2), .V(V2), .Y(Y2), .sat(sat2), .busy(busy2), .done(done2));

  localparam logic [63:0] A_ID = 64'h1000_0100_0010_0001;
  int vectors = 0;
  int miscompares = 0;
  logic [51:0] q0[$];
  logic [51:0] q1[$];
  logic [51:0] q2[$];
  logic [47:0] y0m;
  logic [31:0] y1m;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic for a 4x4, 4-bit-element instance with ow-bit outputs.
  function automatic logic [51:0] model(input logic [63:0] a, input logic [15:0] v, input logic sm,
                                        input logic am, input logic [47:0] prev, input int ow);
    logic [63:0] y64, mask, p;
    logic [3:0] s;
    longint acc, ae, ve, lo, hi;
    y64 = '0;
    s = '0;
    mask = (64'd1 << ow) - 64'd1;
    lo = sm ? -(longint'(1) << (ow - 1)) : 0;
    hi = sm ? (longint'(1) << (ow - 1)) - 1 : (longint'(1) << ow) - 1;
    for (int r = 0; r < 4; r++) begin
      p = ({16'b0, prev} >> (r * ow)) & mask;
      acc = 0;
      if (am) acc = (sm && p[ow-1]) ? longint'(p) - (longint'(1) << ow) : longint'(p);
      for (int c = 0; c < 4; c++) begin
        ae = longint'(a[(r*4+c)*4 +: 4]);
        ve = longint'(v[c*4 +: 4]);
        if (sm && ae >= 8) ae = ae - 16;
        if (sm && ve >= 8) ve = ve - 16;
        acc = acc + ae * ve;
      end
      if (acc > hi) begin acc = hi; s[r] = 1'b1; end
      else if (acc < lo) begin acc = lo; s[r] = 1'b1; end
      y64 = y64 | ((64'(acc) & mask) << (r * ow));
    end
    return {s, y64[47:0]};
  endfunction

  // Drive one operation, scramble inputs two cycles after accept, wait (bounded) for done.
  task automatic go0(input logic [63:0] a, input logic [15:0] v, input logic sm, input logic am,
                     output int lat, output int bc, output bit moved);
    logic [47:0] y_hold;
    A0 = a; V0 = v; sm0 = sm; am0 = am; start0 = 1'b1;
    tick;
    start0 = 1'b0;
    y_hold = Y0;
    bc = busy0 ? 1 : 0;
    lat = 0;
    moved = 0;
    while (!done0 && lat < 40) begin
      tick;
      lat++;
      if (busy0) begin bc++; if (Y0 !== y_hold) moved = 1; end
      if (lat == 2) begin A0 = {$urandom, $urandom}; V0 = 16'($urandom); sm0 = ~sm; am0 = ~am; end
    end
  endtask

  task automatic go1(input logic [63:0] a, input logic [15:0] v, input logic sm, input logic am,
                     output int lat);
    A1 = a; V1 = v; sm1 = sm; am1 = am; start1 = 1'b1;
    tick;
    start1 = 1'b0;
    lat = 0;
    while (!done1 && lat < 40) begin
      tick;
      lat++;
      if (lat == 2) begin A1 = {$urandom, $urandom}; V1 = 16'($urandom); sm1 = ~sm; am1 = ~am; end
    end
  endtask

  task automatic go2(input logic [11:0] a, input logic [5:0] v, output int lat, output int bc);
    A2 = a; V2 = v; sm2 = 1'b0; am2 = 1'b0; start2 = 1'b1;
    tick;
    start2 = 1'b0;
    bc = busy2 ? 1 : 0;
    lat = 0;
    while (!done2 && lat < 40) begin
      tick;
      lat++;
      if (busy2) bc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    vectors++; if (Y0 !== 48'h0 || sat0 !== 4'h0) begin miscompares++; $display("FAIL reset_y0: got %h/%h, want 0/0", Y0, sat0); end
    vectors++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin miscompares++; $display("FAIL reset_ctl0: got busy %b done %b, want 0 0", busy0, done0); end
    vectors++; if (Y1 !== 32'h0 || Y2 !== 12'h0 || busy1 !== 1'b0 || busy2 !== 1'b0) begin miscompares++; $display("FAIL reset_others: got %h %h %b %b, want zeros", Y1, Y2, busy1, busy2); end
    rst = 1'b0;
    y0m = '0;
    y1m = '0;
  endtask

  task automatic test_identity;
    logic [51:0] e;
    int lat, bc;
    bit mv;
    q0.push_back({4'h0, 48'h004_003_002_001});
    go0(A_ID, 16'h4321, 1'b0, 1'b0, lat, bc, mv);
    e = q0.pop_front();
    y0m = e[47:0];
    vectors++; if (Y0 !== e[47:0]) begin miscompares++; $display("FAIL ident_y: got %h, want %h", Y0, e[47:0]); end
    vectors++; if (sat0 !== e[51:48]) begin miscompares++; $display("FAIL ident_sat: got %b, want %b", sat0, e[51:48]); end
    vectors++; if (lat !== 16) begin miscompares++; $display("FAIL ident_latency: got %0d, want 16", lat); end
    vectors++; if (bc !== 16) begin miscompares++; $display("FAIL ident_busy_cycles: got %0d, want 16", bc); end
    vectors++; if (mv !== 1'b0) begin miscompares++; $display("FAIL ident_y_stable: got moved=%b, want 0", mv); end
    tick;
    vectors++; if (done0 !== 1'b0) begin miscompares++; $display("FAIL ident_done_pulse: got %b, want 0", done0); end
  endtask

  task automatic test_saturation;
    logic [51:0] e;
    int lat, bc;
    bit mv;
    q1.push_back({4'hF, 16'h0, 32'hFF_FF_FF_FF});
    go1({64{1'b1}}, 16'hFFFF, 1'b0, 1'b0, lat);
    e = q1.pop_front();
    y1m = e[31:0];
    vectors++; if (Y1 !== e[31:0]) begin miscompares++; $display("FAIL usat8_y: got %h, want %h", Y1, e[31:0]); end
    vectors++; if (sat1 !== e[51:48]) begin miscompares++; $display("FAIL usat8_sat: got %b, want %b", sat1, e[51:48]); end
    vectors++; if (lat !== 16) begin miscompares++; $display("FAIL usat8_latency: got %0d, want 16", lat); end
    q0.push_back({4'h0, 48'h384_384_384_384});
    go0({64{1'b1}}, 16'hFFFF, 1'b0, 1'b0, lat, bc, mv);
    e = q0.pop_front();
    y0m = e[47:0];
    vectors++; if (Y0 !== e[47:0]) begin miscompares++; $display("FAIL u900_y: got %h, want %h", Y0, e[47:0]); end
    vectors++; if (sat0 !== e[51:48]) begin miscompares++; $display("FAIL u900_sat: got %b, want %b", sat0, e[51:48]); end
  endtask

  task automatic test_signed;
    logic [51:0] e;
    int lat, bc;
    bit mv;
    q0.push_back({4'h0, 48'hF20_F20_F20_F20});
    go0(64'h8888_8888_8888_8888, 16'h7777, 1'b1, 1'b0, lat, bc, mv);
    e = q0.pop_front();
    y0m = e[47:0];
    vectors++; if (Y0 !== e[47:0]) begin miscompares++; $display("FAIL signed_y: got %h, want %h", Y0, e[47:0]); end
    vectors++; if (sat0 !== e[51:48]) begin miscompares++; $display("FAIL signed_sat: got %b, want %b", sat0, e[51:48]); end
    q1.push_back({4'hF, 16'h0, 32'h80_80_80_80});
    go1(64'h8888_8888_8888_8888, 16'h7777, 1'b1, 1'b0, lat);
    e = q1.pop_front();
    y1m = e[31:0];
    vectors++; if (Y1 !== e[31:0]) begin miscompares++; $display("FAIL ssat8_y: got %h, want %h", Y1, e[31:0]); end
    vectors++; if (sat1 !== e[51:48]) begin miscompares++; $display("FAIL ssat8_sat: got %b, want %b", sat1, e[51:48]); end
  endtask

  task automatic test_back_to_back;
    logic [51:0] e;
    int lat, bc;
    bit mv;
    q0.push_back({4'h0, 48'h004_003_002_001});
    go0(A_ID, 16'h4321, 1'b0, 1'b0, lat, bc, mv);
    e = q0.pop_front();
    vectors++; if (Y0 !== e[47:0]) begin miscompares++; $display("FAIL b2b_first_y: got %h, want %h", Y0, e[47:0]); end
    q0.push_back({4'h0, 48'h008_006_004_002});
    go0(A_ID, 16'h4321, 1'b0, 1'b1, lat, bc, mv);
    e = q0.pop_front();
    y0m = e[47:0];
    vectors++; if (Y0 !== e[47:0]) begin miscompares++; $display("FAIL b2b_acc_y: got %h, want %h", Y0, e[47:0]); end
    vectors++; if (lat !== 16) begin miscompares++; $display("FAIL b2b_latency: got %0d, want 16", lat); end
    vectors++; if (mv !== 1'b0) begin miscompares++; $display("FAIL b2b_y_stable: got moved=%b, want 0", mv); end
  endtask

  task automatic test_abort;
    logic [51:0] e;
    int lat, bc;
    bit mv, seen;
    seen = 0;
    A0 = A_ID; V0 = 16'h4321; sm0 = 1'b0; am0 = 1'b0; start0 = 1'b1;
    tick;
    start0 = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (i == 2) begin A0 = {$urandom, $urandom}; V0 = 16'($urandom); end
      start0 = (i == 5);
      rst = (i == 9);
      tick;
      if (done0) seen = 1;
      if (i == 6) begin
        vectors++; if (busy0 !== 1'b1) begin miscompares++; $display("FAIL abort_busy_mid: got %b, want 1", busy0); end
      end
    end
    start0 = 1'b0;
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL abort_no_done: got seen=%b, want 0", seen); end
    vectors++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin miscompares++; $display("FAIL abort_ctl: got busy %b done %b, want 0 0", busy0, done0); end
    vectors++; if (Y0 !== 48'h0 || sat0 !== 4'h0) begin miscompares++; $display("FAIL abort_y: got %h/%b, want 0/0", Y0, sat0); end
    rst = 1'b0;
    y0m = '0;
    y1m = '0;
    q0.push_back({4'h0, 48'h004_003_002_001});
    go0(A_ID, 16'h4321, 1'b0, 1'b0, lat, bc, mv);
    e = q0.pop_front();
    y0m = e[47:0];
    vectors++; if (Y0 !== e[47:0] || lat !== 16) begin miscompares++; $display("FAIL abort_rerun: got %h lat %0d, want %h lat 16", Y0, lat, e[47:0]); end
  endtask

  task automatic test_small;
    logic [51:0] e;
    int lat, bc;
    q2.push_back(52'({2'b01, 6'd13, 6'd63}));
    go2({3'd2, 3'd1, 3'd7, 3'd7}, {3'd3, 3'd7}, lat, bc);
    e = q2.pop_front();
    vectors++; if (Y2 !== e[11:0]) begin miscompares++; $display("FAIL small_y: got %h, want %h", Y2, e[11:0]); end
    vectors++; if (sat2 !== e[13:12]) begin miscompares++; $display("FAIL small_sat: got %b, want %b", sat2, e[13:12]); end
    vectors++; if (lat !== 4 || bc !== 4) begin miscompares++; $display("FAIL small_timing: got lat %0d busy %0d, want 4 4", lat, bc); end
  endtask

  task automatic test_random;
    logic [51:0] e;
    logic [63:0] a;
    logic [15:0] v;
    logic sm, am;
    int lat, bc;
    bit mv;
    for (int k = 0; k < 10; k++) begin
      a = {$urandom, $urandom}; v = 16'($urandom); sm = 1'($urandom); am = 1'($urandom);
      q0.push_back(model(a, v, sm, am, y0m, 12));
      go0(a, v, sm, am, lat, bc, mv);
      e = q0.pop_front();
      y0m = e[47:0];
      vectors++; if (Y0 !== e[47:0] || sat0 !== e[51:48]) begin miscompares++; $display("FAIL rand12_%0d: got %h/%b, want %h/%b", k, Y0, sat0, e[47:0], e[51:48]); end
    end
    for (int k = 0; k < 6; k++) begin
      a = {$urandom, $urandom}; v = 16'($urandom); sm = 1'($urandom); am = 1'($urandom);
      q1.push_back(model(a, v, sm, am, {16'h0, y1m}, 8));
      go1(a, v, sm, am, lat);
      e = q1.pop_front();
      y1m = e[31:0];
      vectors++; if (Y1 !== e[31:0] || sat1 !== e[51:48]) begin miscompares++; $display("FAIL rand8_%0d: got %h/%b, want %h/%b", k, Y1, sat1, e[31:0], e[51:48]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    start0 = 1'b0; sm0 = 1'b0; am0 = 1'b0; A0 = '0; V0 = '0;
    start1 = 1'b0; sm1 = 1'b0; am1 = 1'b0; A1 = '0; V1 = '0;
    start2 = 1'b0; sm2 = 1'b0; am2 = 1'b0; A2 = '0; V2 = '0;
    test_reset;
    test_identity;
    test_saturation;
    test_signed;
    test_back_to_back;
    test_abort;
    test_small;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/matrix_vector_mac.md
Name: matrix_vector_mac

Overview:
Parametrised N x N matrix by N-vector multiplier.
- Uses one multiply-accumulate per clock in row-major order.
- Supports signed and unsigned operands and saturating outputs, with per-row saturation flags.
- Optional accumulate mode adds the new product to the previous result (Y += A*V).
- Sits between the operand register file and the display/result path as the compute engine for matrix ops.

Parameters:
- N, 4, matrix dimension and vector length (2..8).
- ELEM_WIDTH, 4, bit width of each A and V element.
- OUT_WIDTH, 12, bit width of each Y element (must be >= 2).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a new operation; accepted only when busy=0.
- signed_mode  in  1  1 = operands are two's complement, 0 = unsigned; sampled at accept.
- acc_mode  in  1  1 = initialise each row accumulator from current Y row; sampled at accept.
- A  in  N*N*ELEM_WIDTH  matrix; element (r,c) at A[(r*N+c)*ELEM_WIDTH +: ELEM_WIDTH].
- V  in  N*ELEM_WIDTH  vector; element c at V[c*ELEM_WIDTH +: ELEM_WIDTH].
- Y  out  N*OUT_WIDTH  result; row r at Y[r*OUT_WIDTH +: OUT_WIDTH].
- sat  out  N  bit r = row r result was clamped in the last operation.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: Y and sat just updated.

Behaviour:
- Reset: Y=0, sat=0, busy=0, done=0; internal row/col counters and accumulator cleared. Reset mid-operation aborts the operation with no done pulse and leaves Y=0.
- States: IDLE, RUN.
- IDLE -> RUN on start=1 at a clock edge (edge E0).
  - At E0, capture A, V, signed_mode and acc_mode into internal registers.
  - Changes to A, V or the mode inputs after E0 have no effect on the running operation.
- RUN: one element (r,c) is processed per edge, starting with (0,0) at E0+1.
  - At edge E0+k (k=1..N*N), process element index k-1, where r=(k-1)/N and c=(k-1)%N.
  - Operation: acc = acc + A[r][c]*V[c].
- Accumulator width:
  - 2*ELEM_WIDTH + clog2(N) + 2 bits, plus OUT_WIDTH+1 bits when acc_mode is set.
  - The accumulator never wraps internally.
- Row start (c=0):
  - acc_mode=0: acc starts from 0.
  - acc_mode=1: acc starts from the current Y row, sign-extended if signed_mode else zero-extended.
- Row end (c=N-1): final sum saturates into a shadow result row.
  - Unsigned: clamp to [0, 2^OUT_WIDTH-1].
  - Signed: clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - The shadow sat bit for the row is set iff clamping occurred.
- Completion: at edge E0+N*N, the last element is processed.
  - Y and sat are loaded from the shadow registers.
  - done=1 for exactly one cycle; busy returns to 0 and the state goes to IDLE.
- Output timing:
  - busy=1 for exactly N*N cycles.
  - Y and sat are stable, holding the previous result, for the whole of RUN.
  - Y and sat never show partial rows.
- start while busy=1 is ignored, with no queueing.
- start in the cycle where done=1 (busy=0) is accepted. With acc_mode=1, that operation uses the just-updated Y.
- Signed multiply: both operands are treated as signed when signed_mode=1. -2^(ELEM_WIDTH-1) is a legal value.

Test Plan:
1. Defaults; A=identity, V=(1,2,3,4), unsigned, start pulse -> done exactly 16 cycles after accept; Y rows = 1,2,3,4; sat=0000; busy high 16 cycles.
2. OUT_WIDTH=8; A and V all 15, unsigned -> each row 900 clamps to 255; sat=1111. Same stimulus with OUT_WIDTH=12 -> each row 900 (12'h384); sat=0000.
3. Defaults, signed_mode=1; A all 4'h8 (-8), V all 7 -> each row -224 = 12'hF20; sat=0000. With OUT_WIDTH=8 -> each row 8'h80 (-128); sat=1111.
4. Test 1, then acc_mode=1 with the same operands, start asserted in the done cycle -> accepted immediately; Y rows = 2,4,6,8 after 16 more cycles.
5. Start, change A/V at accept+2, pulse start at accept+5, assert reset at accept+9 -> start ignored, no done, Y=0, busy=0 next cycle. Fresh Test 1 start afterwards completes normally.
6. N=2, ELEM_WIDTH=3, OUT_WIDTH=6, unsigned; A=((7,7),(1,2)), V=(7,3) -> rows 70 clamps to 63 and 13; sat=01; done after 4 cycles.
